minibyte_timer_io: RTL and testbench

- Memory-mapped 8-bit prescaled timer peripheral on the minibyte CPU address/data bus, alongside the onboard register RAM.
- Consumes the CPU address bus, write data and WE.
- Produces read data and a window-select flag; the top-level input mux uses these to route timer reads onto the CPU data input.
- Provides a sticky compare-match flag and a level interrupt output for polled or demo-ROM timing loops.

---
 rtl/minibyte_timer_io.sv | 116 +++++++++++
 tb/tb_minibyte_timer_io.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minibyte_timer_io.sv
// rtl/minibyte_timer_io.sv - memory-mapped 8-bit prescaled timer for the minibyte CPU bus
// Four-register window (CTRL, PRESCALE, COUNT, COMPARE) with a sticky match flag and a level interrupt.
module minibyte_timer_io #(
  parameter logic [6:0] BASE_ADDR = 7'h70
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [6:0] address,
  input  logic [7:0] data_in,
  input  logic       we_in,
  output logic       sel_out,
  output logic [7:0] data_out,
  output logic       irq_out,
  output logic       tick_out
);

  logic       en;
  logic       reload;
  logic       ie;
  logic       match;
  logic [7:0] prescale;
  logic [7:0] count;
  logic [7:0] compare;
  logic [7:0] pre_cnt;

  logic wr;
  logic wr_ctrl;
  logic wr_prescale;
  logic wr_count;
  logic wr_compare;
  logic en_rise;
  logic tick;
  logic timer_tick;
  logic hit;

  assign sel_out     = (address[6:2] == BASE_ADDR[6:2]);
  assign wr          = we_in & sel_out;
  assign wr_ctrl     = wr & (address[1:0] == 2'd0);
  assign wr_prescale = wr & (address[1:0] == 2'd1);
  assign wr_count    = wr & (address[1:0] == 2'd2);
  assign wr_compare  = wr & (address[1:0] == 2'd3);
  assign en_rise     = wr_ctrl & data_in[0] & ~en;

  assign tick       = en & (pre_cnt == prescale);
  assign tick_out   = tick;
  // A COUNT write in a tick cycle swallows that tick entirely.
  assign timer_tick = tick & ~wr_count;
  assign hit        = timer_tick & (count == compare);

  assign irq_out = match & ie;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      en       <= 1'b0;
      reload   <= 1'b0;
      ie       <= 1'b0;
      match    <= 1'b0;
      prescale <= 8'h00;
      count    <= 8'h00;
      compare  <= 8'h00;
      pre_cnt  <= 8'h00;
    end else begin
      if (wr_count || en_rise || !en || tick) begin
        pre_cnt <= 8'h00;
      end else begin
        pre_cnt <= pre_cnt + 8'd1;
      end

      if (timer_tick) begin
        if (count == compare) begin
          match <= 1'b1;
          if (reload) begin
            count <= 8'h00;
          end else begin
            en <= 1'b0;
          end
        end else begin
          count <= count + 8'd1;
        end
      end

      // CPU writes come after the timer update so they win, except that a
      // match event in the same cycle is never cleared away.
      if (wr_count) begin
        count <= data_in;
      end
      if (wr_ctrl) begin
        en     <= data_in[0];
        reload <= data_in[1];
        ie     <= data_in[6];
        if (data_in[7] && !hit) begin
          match <= 1'b0;
        end
      end
      if (wr_prescale) begin
        prescale <= data_in;
      end
      if (wr_compare) begin
        compare <= data_in;
      end
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (sel_out) begin
      case (address[1:0])
        2'd0:    data_out = {match, ie, 4'b0000, reload, en};
        2'd1:    data_out = prescale;
        2'd2:    data_out = count;
        default: data_out = compare;
      endcase
    end
  end

endmodule

// File: tb/tb_minibyte_timer_io.sv
// tb/tb_minibyte_timer_io.sv - directed self-checking bench for minibyte_timer_io
module tb_minibyte_timer_io;

  localparam logic [6:0] A_CTRL = 7'h70;
  localparam logic [6:0] A_PRE  = 7'h71;
  localparam logic [6:0] A_CNT  = 7'h72;
  localparam logic [6:0] A_CMP  = 7'h73;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [6:0] address;
  logic [7:0] data_in;
  logic       we_in;
  logic       sel_out;
  logic [7:0] data_out;
  logic       irq_out;
  logic       tick_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  minibyte_timer_io #(.BASE_ADDR(7'h70)) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .address (address),
    .data_in (data_in),
    .we_in   (we_in),
    .sel_out (sel_out),
    .data_out(data_out),
    .irq_out (irq_out),
    .tick_out(tick_out)
  );

  task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk_in);
    address = a;
    data_in = d;
    we_in   = 1'b1;
    @(posedge clk_in);
    #1;
    we_in = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [6:0] regs [4];
    regs = '{A_CTRL, A_PRE, A_CNT, A_CMP};
    rst_in = 1'b0;
    we_in = 1'b0;
    address = 7'h00;
    data_in = 8'h00;
    #12 rst_in = 1'b1;
    bus_write(A_PRE, 8'h00);
    bus_write(A_CMP, 8'hFF);
    bus_write(A_CTRL, 8'h41);
    bus_write(A_CNT, 8'h05);
    rd(A_CNT, d);
    checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL reset_pre_count got=%h exp=05", d); end
    checks++;
    if (tick_out !== 1'b1) begin failures++; $display("FAIL reset_pre_tick got=%b exp=1", tick_out); end
    #1 rst_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(regs[i], d);
      checks++;
      if (d !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00", i, d); end
    end
    checks++;
    if (irq_out !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_out); end
    checks++;
    if (tick_out !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_reload();
    logic [7:0] d;
    bus_write(A_PRE, 8'h02);
    bus_write(A_CMP, 8'h03);
    bus_write(A_CTRL, 8'h43);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in);
      #1;
      checks++;
      if (tick_out !== (k % 3 == 2)) begin failures++; $display("FAIL reload_tick k=%0d got=%b exp=%b", k, tick_out, (k % 3 == 2)); end
      rd(A_CNT, d);
      checks++;
      if (d !== ((k == 12) ? 8'h00 : 8'(k / 3))) begin failures++; $display("FAIL reload_count k=%0d got=%h exp=%h", k, d, (k == 12) ? 8'h00 : 8'(k / 3)); end
      rd(A_CTRL, d);
      checks++;
      if (d !== ((k == 12) ? 8'hC3 : 8'h43)) begin failures++; $display("FAIL reload_ctrl k=%0d got=%h exp=%h", k, d, (k == 12) ? 8'hC3 : 8'h43); end
      checks++;
      if (irq_out !== (k == 12)) begin failures++; $display("FAIL reload_irq k=%0d got=%b exp=%b", k, irq_out, (k == 12)); end
    end
    bus_write(A_CTRL, 8'hC3);
    checks++;
    if (irq_out !== 1'b0) begin failures++; $display("FAIL reload_irq_clear got=%b exp=0", irq_out); end
    rd(A_CTRL, d);
    checks++;
    if (d !== 8'h43) begin failures++; $display("FAIL reload_ctrl_clear got=%h exp=43", d); end
    bus_write(A_CTRL, 8'h00);
  endtask

  task automatic test_one_shot();
    logic [7:0] d;
    bus_write(A_CTRL, 8'h80);
    bus_write(A_CNT, 8'h00);
    bus_write(A_PRE, 8'h00);
    bus_write(A_CMP, 8'h05);
    bus_write(A_CTRL, 8'h01);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_in);
      #1;
      rd(A_CNT, d);
      checks++;
      if (d !== ((k <= 5) ? 8'(k) : 8'h05)) begin failures++; $display("FAIL oneshot_count k=%0d got=%h exp=%h", k, d, (k <= 5) ? 8'(k) : 8'h05); end
      rd(A_CTRL, d);
      checks++;
      if (d !== ((k == 6) ? 8'h80 : 8'h01)) begin failures++; $display("FAIL oneshot_ctrl k=%0d got=%h exp=%h", k, d, (k == 6) ? 8'h80 : 8'h01); end
    end
    repeat (20) @(posedge clk_in);
    #1;
    rd(A_CNT, d);
    checks++;
    if (d !== 8'h05) begin failures++; $display("FAIL oneshot_hold got=%h exp=05", d); end
    checks++;
    if (tick_out !== 1'b0) begin failures++; $display("FAIL oneshot_tick got=%b exp=0", tick_out); end
  endtask

  task automatic test_collisions();
    logic [7:0] d;
    bus_write(A_CTRL, 8'h80);
    bus_write(A_CNT, 8'h00);
    bus_write(A_PRE, 8'h02);
    bus_write(A_CMP, 8'h50);
    bus_write(A_CTRL, 8'h03);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    checks++;
    if (tick_out !== 1'b1) begin failures++; $display("FAIL coll_tick_pre got=%b exp=1", tick_out); end
    bus_write(A_CNT, 8'h10);
    rd(A_CNT, d);
    checks++;
    if (d !== 8'h10) begin failures++; $display("FAIL coll_count_write got=%h exp=10", d); end
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_in);
      #1;
      rd(A_CNT, d);
      checks++;
      if (d !== ((k == 3) ? 8'h11 : 8'h10)) begin failures++; $display("FAIL coll_restart k=%0d got=%h exp=%h", k, d, (k == 3) ? 8'h11 : 8'h10); end
    end
    bus_write(A_CTRL, 8'h80);
    bus_write(A_CNT, 8'h00);
    bus_write(A_CMP, 8'h02);
    bus_write(A_PRE, 8'h00);
    bus_write(A_CTRL, 8'h83);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rd(A_CNT, d);
    checks++;
    if (d !== 8'h02) begin failures++; $display("FAIL coll_match_pre got=%h exp=02", d); end
    bus_write(A_CTRL, 8'h83);
    rd(A_CTRL, d);
    checks++;
    if (d !== 8'h83) begin failures++; $display("FAIL coll_match_keep got=%h exp=83", d); end
    rd(A_CNT, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_match_reload got=%h exp=00", d); end
    bus_write(A_CTRL, 8'h80);
    rd(A_CTRL, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL coll_match_clear got=%h exp=00", d); end
  endtask

  task automatic test_decode();
    logic [7:0] d;
    logic [6:0] bad [3];
    logic [6:0] regs [4];
    logic [7:0] vals [4];
    bad  = '{7'h6F, 7'h74, 7'h78};
    regs = '{A_CTRL, A_PRE, A_CNT, A_CMP};
    vals = '{8'h40, 8'h21, 8'h22, 8'h23};
    bus_write(A_PRE, 8'h21);
    bus_write(A_CNT, 8'h22);
    bus_write(A_CMP, 8'h23);
    bus_write(A_CTRL, 8'h40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      address = bad[i];
      data_in = 8'hFF;
      we_in   = 1'b1;
      #1;
      checks++;
      if (sel_out !== 1'b0) begin failures++; $display("FAIL decode_sel addr=%h got=%b exp=0", bad[i], sel_out); end
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL decode_data addr=%h got=%h exp=00", bad[i], data_out); end
      @(posedge clk_in);
      #1;
      we_in = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      rd(regs[i], d);
      checks++;
      if (d !== vals[i]) begin failures++; $display("FAIL decode_keep reg%0d got=%h exp=%h", i, d, vals[i]); end
    end
    address = 7'h73;
    #1;
    checks++;
    if (sel_out !== 1'b1) begin failures++; $display("FAIL decode_sel73 got=%b exp=1", sel_out); end
    checks++;
    if (data_out !== 8'h23) begin failures++; $display("FAIL decode_data73 got=%h exp=23", data_out); end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    logic [7:0] exp_cnt [5];
    exp_cnt = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h02};
    bus_write(A_CTRL, 8'h00);
    bus_write(A_CMP, 8'h02);
    bus_write(A_CNT, 8'hFE);
    bus_write(A_PRE, 8'h00);
    bus_write(A_CTRL, 8'h01);
    rd(A_CNT, d);
    checks++;
    if (d !== 8'hFE) begin failures++; $display("FAIL wrap_start got=%h exp=FE", d); end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_in);
      #1;
      rd(A_CNT, d);
      checks++;
      if (d !== exp_cnt[k-1]) begin failures++; $display("FAIL wrap_count k=%0d got=%h exp=%h", k, d, exp_cnt[k-1]); end
      rd(A_CTRL, d);
      checks++;
      if (d !== ((k == 5) ? 8'h80 : 8'h01)) begin failures++; $display("FAIL wrap_ctrl k=%0d got=%h exp=%h", k, d, (k == 5) ? 8'h80 : 8'h01); end
    end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_one_shot();
    test_collisions();
    test_decode();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
